// File: rtl/cv32e40x_pkg.sv
// rtl/cv32e40x_pkg.sv - shared branch predictor types and constants
package cv32e40x_pkg;

    localparam int unsigned BP_ENTRIES   = 16;
    localparam int unsigned BP_TAG_WIDTH = 8;
    localparam int unsigned BP_CNT_WIDTH = 2;
    localparam int unsigned BP_IDX_W     = $clog2(BP_ENTRIES);

    typedef struct packed {
        logic                    valid;
        logic [BP_TAG_WIDTH-1:0] tag;
        logic [31:1]             target;
        logic [BP_CNT_WIDTH-1:0] cnt;
    } bp_entry_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
    } bp_upd_t;

    // Weakly-taken value: only the counter MSB set.
    function automatic logic [3:0] bp_cnt_weak_taken(input int unsigned cnt_width);
        return 4'(1) << (cnt_width - 1);
    endfunction

    localparam logic [BP_CNT_WIDTH-1:0] BP_CNT_WEAK_TAKEN =
        BP_CNT_WIDTH'(bp_cnt_weak_taken(BP_CNT_WIDTH));

endpackage

// File: rtl/cv32e40x_bp_counter.sv
// rtl/cv32e40x_bp_counter.sv - saturating up/down direction counter update
module cv32e40x_bp_counter #(
    parameter int unsigned CNT_WIDTH = 2
) (
    input  logic [CNT_WIDTH-1:0] cnt_i,
    input  logic                 up_i,
    output logic [CNT_WIDTH-1:0] cnt_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    always_comb begin
        cnt_o = cnt_i;
        if (up_i) begin
            if (cnt_i != CNT_MAX) cnt_o = cnt_i + CNT_WIDTH'(1);
        end else begin
            if (cnt_i != '0) cnt_o = cnt_i - CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/cv32e40x_branch_predictor.sv
// rtl/cv32e40x_branch_predictor.sv - direct-mapped BTB with counters; perf counters under CV32E40X_BP_PERF_EN
module cv32e40x_branch_predictor
    import cv32e40x_pkg::*;
#(
    parameter int unsigned ENTRIES   = 16,
    parameter int unsigned TAG_WIDTH = 8,
    parameter int unsigned CNT_WIDTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_if_i,
    output logic        hit_o,
    output logic        taken_o,
    output logic [31:0] target_o,
    input  logic        upd_valid_i,
    input  logic [31:0] upd_pc_i,
    input  logic        upd_taken_i,
    input  logic [31:0] upd_target_i,
    input  logic        upd_mispredict_i,
    input  logic        flush_i,
    output logic [31:0] perf_lookups_o,
    output logic [31:0] perf_hits_o,
    output logic [31:0] perf_mispred_o
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam logic [CNT_WIDTH-1:0] CNT_WEAK = CNT_WIDTH'(bp_cnt_weak_taken(CNT_WIDTH));

    typedef struct packed {
        logic                 valid;
        logic [TAG_WIDTH-1:0] tag;
        logic [31:1]          target;
        logic [CNT_WIDTH-1:0] cnt;
    } entry_t;

    entry_t  tbl_q [ENTRIES];
    bp_upd_t pend_q, pend_d;

    logic [IDX_W-1:0]     lk_idx, wr_idx;
    logic [TAG_WIDTH-1:0] lk_tag, wr_tag;
    entry_t               lk_e, wr_e;
    logic                 wr_hit;
    logic [CNT_WIDTH-1:0] cnt_nxt;

    assign lk_idx = pc_if_i[IDX_W:1];
    assign lk_tag = pc_if_i[IDX_W+TAG_WIDTH:IDX_W+1];
    assign lk_e   = tbl_q[lk_idx];

    assign hit_o    = lk_e.valid && (lk_e.tag == lk_tag);
    assign taken_o  = hit_o && lk_e.cnt[CNT_WIDTH-1];
    assign target_o = hit_o ? {lk_e.target, 1'b0} : 32'h0;

    assign wr_idx = pend_q.pc[IDX_W:1];
    assign wr_tag = pend_q.pc[IDX_W+TAG_WIDTH:IDX_W+1];
    assign wr_e   = tbl_q[wr_idx];
    assign wr_hit = wr_e.valid && (wr_e.tag == wr_tag);

    cv32e40x_bp_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_counter (
        .cnt_i (wr_e.cnt),
        .up_i  (pend_q.taken),
        .cnt_o (cnt_nxt)
    );

    always_comb begin
        pend_d = '0;
        if (upd_valid_i && !flush_i) begin
            pend_d.valid  = 1'b1;
            pend_d.pc     = upd_pc_i;
            pend_d.taken  = upd_taken_i;
            pend_d.target = upd_target_i;
        end
    end

    // Flush takes priority over the pending write; a capture is suppressed via pend_d.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(ENTRIES); i++) tbl_q[i] <= '0;
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
            if (flush_i) begin
                for (int i = 0; i < int'(ENTRIES); i++) tbl_q[i].valid <= 1'b0;
            end else if (pend_q.valid) begin
                if (wr_hit) begin
                    tbl_q[wr_idx].cnt <= cnt_nxt;
                    if (pend_q.taken) tbl_q[wr_idx].target <= pend_q.target[31:1];
                end else if (pend_q.taken) begin
                    tbl_q[wr_idx].valid  <= 1'b1;
                    tbl_q[wr_idx].tag    <= wr_tag;
                    tbl_q[wr_idx].target <= pend_q.target[31:1];
                    tbl_q[wr_idx].cnt    <= CNT_WEAK;
                end
            end
        end
    end

`ifdef CV32E40X_BP_PERF_EN
    logic [31:0] perf_lookups_q, perf_hits_q, perf_mispred_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_lookups_q <= '0;
            perf_hits_q    <= '0;
            perf_mispred_q <= '0;
        end else begin
            perf_lookups_q <= perf_lookups_q + 32'd1;
            if (hit_o) perf_hits_q <= perf_hits_q + 32'd1;
            if (upd_valid_i && upd_mispredict_i) perf_mispred_q <= perf_mispred_q + 32'd1;
        end
    end

    assign perf_lookups_o = perf_lookups_q;
    assign perf_hits_o    = perf_hits_q;
    assign perf_mispred_o = perf_mispred_q;

    logic unused_bits;
    assign unused_bits = ^{pc_if_i, pend_q};
`else
    assign perf_lookups_o = 32'h0;
    assign perf_hits_o    = 32'h0;
    assign perf_mispred_o = 32'h0;

    logic unused_bits;
    assign unused_bits = ^{pc_if_i, pend_q, upd_mispredict_i};
`endif

endmodule

// File: tb/tb_cv32e40x_branch_predictor.sv
// tb/tb_cv32e40x_branch_predictor.sv - self-checking bench with behavioural BTB model
module tb_cv32e40x_branch_predictor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_if = '0;
    logic        hit, taken;
    logic [31:0] target;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = '0;
    logic        upd_mispredict = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] perf_lookups, perf_hits, perf_mispred;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    cv32e40x_branch_predictor #(
        .ENTRIES   (16),
        .TAG_WIDTH (8),
        .CNT_WIDTH (2)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .pc_if_i          (pc_if),
        .hit_o            (hit),
        .taken_o          (taken),
        .target_o         (target),
        .upd_valid_i      (upd_valid),
        .upd_pc_i         (upd_pc),
        .upd_taken_i      (upd_taken),
        .upd_target_i     (upd_target),
        .upd_mispredict_i (upd_mispredict),
        .flush_i          (flush),
        .perf_lookups_o   (perf_lookups),
        .perf_hits_o      (perf_hits),
        .perf_mispred_o   (perf_mispred)
    );

    // Reference model: 16 direct-mapped entries, 8-bit tag, counter range 0..3.
    bit          m_valid [16];
    int          m_tag   [16];
    logic [31:0] m_tgt   [16];
    int          m_cnt   [16];
    bit          p_valid;
    logic [31:0] p_pc, p_target;
    bit          p_taken;
    logic [31:0] m_lookups, m_hits, m_mispred;

    function automatic int m_idx(input logic [31:0] pc);
        return int'((pc >> 1) & 32'hF);
    endfunction

    function automatic int m_tagof(input logic [31:0] pc);
        return int'((pc >> 5) & 32'hFF);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == m_tagof(pc));
    endfunction

    function automatic bit m_taken(input logic [31:0] pc);
        return m_hit(pc) && (m_cnt[m_idx(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_target(input logic [31:0] pc);
        return m_hit(pc) ? m_tgt[m_idx(pc)] : 32'h0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = '0; m_cnt[i] = 0;
        end
        p_valid = 0;
        m_lookups = '0; m_hits = '0; m_mispred = '0;
    endtask

    task automatic model_edge();
        int i;
        m_lookups = m_lookups + 1;
        if (m_hit(pc_if)) m_hits = m_hits + 1;
        if (upd_valid && upd_mispredict) m_mispred = m_mispred + 1;
        if (flush) begin
            for (int k = 0; k < 16; k++) m_valid[k] = 0;
            p_valid = 0;
        end else begin
            if (p_valid) begin
                i = m_idx(p_pc);
                if (m_hit(p_pc)) begin
                    if (p_taken) begin
                        m_cnt[i] = (m_cnt[i] < 3) ? m_cnt[i] + 1 : 3;
                        m_tgt[i] = p_target & ~32'h1;
                    end else begin
                        m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
                    end
                end else if (p_taken) begin
                    m_valid[i] = 1;
                    m_tag[i]   = m_tagof(p_pc);
                    m_tgt[i]   = p_target & ~32'h1;
                    m_cnt[i]   = 2;
                end
            end
            p_valid  = upd_valid;
            p_pc     = upd_pc;
            p_taken  = upd_taken;
            p_target = upd_target;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        upd_valid = 1'b0;
        upd_mispredict = 1'b0;
        flush = 1'b0;
    endtask

    task automatic set_upd(input logic [31:0] pc, input bit tk, input logic [31:0] tg, input bit mp);
        upd_valid = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tg; upd_mispredict = mp;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_clear();
        #2;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        pc_if = 32'h100;
        #1;
        total++;
        if ({hit, taken, target} !== 34'h0) $display("FAIL reset_lookup: got hit=%0b taken=%0b target=%h want 0/0/0", hit, taken, target);
        else passed++;
        total++;
        if ({perf_lookups, perf_hits, perf_mispred} !== 96'h0) $display("FAIL reset_perf: got %0d/%0d/%0d want 0/0/0", perf_lookups, perf_hits, perf_mispred);
        else passed++;
    endtask

    task automatic test_allocate();
        pc_if = 32'h100;
        set_upd(32'h100, 1, 32'h200, 0);
        tick();
        #1;
        total++;
        if (hit !== 1'b0) $display("FAIL alloc_not_yet_visible: got hit=%0b want 0", hit);
        else passed++;
        tick();
        #1;
        total++;
        if ({hit, taken, target} !== {1'b1, 1'b1, 32'h200}) $display("FAIL alloc_visible: got hit=%0b taken=%0b target=%h want 1/1/00000200", hit, taken, target);
        else passed++;
    endtask

    task automatic test_counter_sat();
        bit exp_nt [3] = '{0, 0, 0};
        bit exp_tk [4] = '{0, 1, 1, 1};
        pc_if = 32'h100;
        for (int k = 0; k < 3; k++) begin
            set_upd(32'h100, 0, 32'h0, 0);
            tick(); tick(); #1;
            total++;
            if (hit !== 1'b1 || taken !== exp_nt[k]) $display("FAIL cnt_dec_%0d: got hit=%0b taken=%0b want 1/%0b", k, hit, taken, exp_nt[k]);
            else passed++;
        end
        for (int k = 0; k < 4; k++) begin
            set_upd(32'h100, 1, 32'h200, 0);
            tick(); tick(); #1;
            total++;
            if (taken !== exp_tk[k] || target !== 32'h200) $display("FAIL cnt_inc_%0d: got taken=%0b target=%h want %0b/00000200", k, taken, target, exp_tk[k]);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        pc_if = 32'h100;
        set_upd(32'h100, 0, 32'h0, 0);
        tick();
        set_upd(32'h100, 0, 32'h0, 0);
        tick(); tick(); #1;
        total++;
        if (hit !== 1'b1 || taken !== 1'b0) $display("FAIL back_to_back: got hit=%0b taken=%0b want 1/0", hit, taken);
        else passed++;
    endtask

    task automatic test_aliasing();
        flush = 1'b1;
        tick();
        set_upd(32'h100, 1, 32'h200, 0);
        tick();
        set_upd(32'h120, 1, 32'h301, 0);
        tick(); tick();
        pc_if = 32'h100; #1;
        total++;
        if (hit !== 1'b0) $display("FAIL alias_old_evicted: got hit=%0b want 0", hit);
        else passed++;
        pc_if = 32'h120; #1;
        total++;
        if ({hit, taken, target} !== {1'b1, 1'b1, 32'h300}) $display("FAIL alias_new: got hit=%0b taken=%0b target=%h want 1/1/00000300", hit, taken, target);
        else passed++;
        set_upd(32'h140, 0, 32'h500, 0);
        tick(); tick();
        pc_if = 32'h140; #1;
        total++;
        if (hit !== 1'b0) $display("FAIL alias_nt_miss_alloc: got hit=%0b want 0", hit);
        else passed++;
        pc_if = 32'h120; #1;
        total++;
        if ({hit, taken, target} !== {1'b1, 1'b1, 32'h300}) $display("FAIL alias_unchanged: got hit=%0b taken=%0b target=%h want 1/1/00000300", hit, taken, target);
        else passed++;
    endtask

    task automatic test_flush();
        logic [31:0] pcs [3] = '{32'h120, 32'h180, 32'h1C0};
        set_upd(32'h180, 1, 32'h800, 0);
        tick();
        set_upd(32'h1C0, 1, 32'h900, 0);
        flush = 1'b1;
        tick();
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 3; k++) begin
                pc_if = pcs[k]; #1;
                total++;
                if (hit !== 1'b0) $display("FAIL flush_r%0d_pc%h: got hit=%0b want 0", r, pcs[k], hit);
                else passed++;
            end
            tick();
        end
    endtask

    task automatic test_perf();
        logic [31:0] e_l, e_h, e_m;
        do_reset();
        pc_if = 32'h0;
        set_upd(32'h100, 1, 32'h200, 0);
        tick();
        tick();
        pc_if = 32'h100;
        set_upd(32'h300, 0, 32'h0, 1);
        tick();
        set_upd(32'h300, 0, 32'h0, 1);
        tick();
        tick(); tick();
        pc_if = 32'h0;
        repeat (4) tick();
`ifdef CV32E40X_BP_PERF_EN
        e_l = 32'd10; e_h = 32'd4; e_m = 32'd2;
`else
        e_l = 32'd0; e_h = 32'd0; e_m = 32'd0;
`endif
        total++;
        if ({perf_lookups, perf_hits, perf_mispred} !== {e_l, e_h, e_m})
            $display("FAIL perf_directed: got %0d/%0d/%0d want %0d/%0d/%0d", perf_lookups, perf_hits, perf_mispred, e_l, e_h, e_m);
        else passed++;
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] pc;
        pc = (32'($urandom_range(0, 3)) << 5) | (32'($urandom_range(0, 7)) << 1) | 32'($urandom_range(0, 1));
        if ($urandom_range(0, 3) == 0) pc = pc | ($urandom << 13);
        return pc;
    endfunction

    task automatic test_random();
        int errs = 0;
        logic [31:0] e_l, e_h, e_m;
        for (int n = 0; n < 400; n++) begin
            pc_if = rand_pc();
            if ($urandom_range(0, 1) == 1)
                set_upd(rand_pc(), 1'($urandom_range(0, 2) != 0), $urandom, 1'($urandom_range(0, 1)));
            flush = ($urandom_range(0, 39) == 0);
            #1;
            total++;
            if (hit !== m_hit(pc_if) || taken !== m_taken(pc_if) || target !== m_target(pc_if)) begin
                if (errs < 10) $display("FAIL random_lookup pc=%h: got %0b/%0b/%h want %0b/%0b/%h",
                    pc_if, hit, taken, target, m_hit(pc_if), m_taken(pc_if), m_target(pc_if));
                errs++;
            end else passed++;
            tick();
        end
`ifdef CV32E40X_BP_PERF_EN
        e_l = m_lookups; e_h = m_hits; e_m = m_mispred;
`else
        e_l = 32'd0; e_h = 32'd0; e_m = 32'd0;
`endif
        total++;
        if ({perf_lookups, perf_hits, perf_mispred} !== {e_l, e_h, e_m})
            $display("FAIL perf_random: got %0d/%0d/%0d want %0d/%0d/%0d", perf_lookups, perf_hits, perf_mispred, e_l, e_h, e_m);
        else passed++;
    endtask

    task automatic test_reset_mid_update();
        set_upd(32'h1E0, 1, 32'hA00, 0);
        tick();
        do_reset();
        tick();
        pc_if = 32'h1E0; #1;
        total++;
        if (hit !== 1'b0) $display("FAIL reset_mid_update: got hit=%0b want 0", hit);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_allocate();
        test_counter_sat();
        test_back_to_back();
        test_aliasing();
        test_flush();
        test_perf();
        test_random();
        test_reset_mid_update();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
